// File: rtl/mem_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bridge_pkg
// Description : Shared state type and line/beat sizing helpers for the
//               cache-line to narrow-bus burst bridge.
// Revision    : 1.0  initial release
// ============================================================================
package mem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2,
        RD_DONE  = 2'd3
    } bridge_state_t;

    function automatic int calc_beats(input int line_size, input int bus_width);
        return (line_size * 8) / bus_width;
    endfunction

    function automatic int calc_off_width(input int line_size);
        return $clog2(line_size);
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_wbuf.sv
`default_nettype none
// ============================================================================
// Module      : line_wbuf
// Description : One-entry posted write-back line buffer with sticky overflow.
// Revision    : 1.0  initial release
// ============================================================================
module line_wbuf
    import mem_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BITS  = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic [LINE_BITS-1:0]  push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  overflow,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [LINE_BITS-1:0]  data
);

    logic                  r_full;
    logic                  r_overflow;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LINE_BITS-1:0]  r_data;
    logic                  w_accept;

    // A push is taken when the slot is empty or is being drained this cycle.
    assign w_accept = push & (~r_full | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
        end else begin
            if (w_accept) begin
                r_full <= 1'b1;
                r_addr <= push_addr;
                r_data <= push_data;
            end else if (pop) begin
                r_full <= 1'b0;
            end
            if (push && !w_accept) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign full     = r_full;
    assign overflow = r_overflow;
    assign addr     = r_addr;
    assign data     = r_data;

endmodule
`default_nettype wire

// File: rtl/mem_burst_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mem_burst_bridge
// Description : Turns whole-line fills and posted write-backs from the cache
//               controller into beat bursts on a narrow backing-memory bus.
// Revision    : 1.0  initial release
// ============================================================================
module mem_burst_bridge
    import mem_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_SIZE  = 64,
    parameter int BUS_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [LINE_SIZE*8-1:0]  mem_write_data,
    input  logic                    mem_read_en,
    input  logic                    mem_write_en,
    output logic [LINE_SIZE*8-1:0]  mem_read_data,
    output logic                    mem_ready,
    output logic                    bus_req,
    output logic                    bus_we,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [BUS_WIDTH-1:0]    bus_wdata,
    input  logic                    bus_gnt,
    input  logic                    bus_rvalid,
    input  logic [BUS_WIDTH-1:0]    bus_rdata,
    output logic                    busy,
    output logic                    wr_overflow
);

    localparam int C_BEATS      = calc_beats(LINE_SIZE, BUS_WIDTH);
    localparam int C_LINE_BITS  = LINE_SIZE * 8;
    localparam int C_OFF_W      = calc_off_width(LINE_SIZE);
    localparam int C_CNT_W      = $clog2(C_BEATS) + 1;
    localparam int C_IDX_W      = (C_BEATS > 1) ? $clog2(C_BEATS) : 1;
    localparam int C_BYTE_SHIFT = $clog2(BUS_WIDTH / 8);
    localparam logic [C_CNT_W-1:0] C_LAST_BEAT = C_CNT_W'(C_BEATS - 1);
    localparam logic [C_CNT_W-1:0] C_ALL_BEATS = C_CNT_W'(C_BEATS);

    bridge_state_t          r_state;
    bridge_state_t          w_state_next;
    logic [C_CNT_W-1:0]     r_issue_cnt;
    logic [C_CNT_W-1:0]     r_resp_cnt;
    logic [C_IDX_W-1:0]     w_issue_idx;
    logic [C_IDX_W-1:0]     w_resp_idx;
    logic [ADDR_WIDTH-1:0]  w_line_base;
    logic [ADDR_WIDTH-1:0]  r_rd_base;
    logic [ADDR_WIDTH-1:0]  w_beat_base;
    logic [ADDR_WIDTH-1:0]  w_beat_addr;
    logic [BUS_WIDTH-1:0]   r_fill [C_BEATS];
    logic [BUS_WIDTH-1:0]   w_wb_beat [C_BEATS];
    logic [C_LINE_BITS-1:0] w_fill_merged;
    logic [C_LINE_BITS-1:0] r_rd_data;
    logic                   w_wb_full;
    logic                   w_wb_pop;
    logic                   w_wb_ovf;
    logic [ADDR_WIDTH-1:0]  w_wb_addr;
    logic [C_LINE_BITS-1:0] w_wb_data;
    logic                   w_issue_more;
    logic                   w_grant;
    logic                   w_last_resp;
    logic                   w_unused;

    assign w_unused    = ^mem_addr[C_OFF_W-1:0];
    assign w_line_base = {mem_addr[ADDR_WIDTH-1:C_OFF_W], {C_OFF_W{1'b0}}};

    line_wbuf #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LINE_BITS  (C_LINE_BITS)
    ) u_wbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (mem_write_en),
        .push_addr (w_line_base),
        .push_data (mem_write_data),
        .pop       (w_wb_pop),
        .full      (w_wb_full),
        .overflow  (w_wb_ovf),
        .addr      (w_wb_addr),
        .data      (w_wb_data)
    );

    // The final beat is merged straight from the bus so the line is complete
    // in the same edge that enters RD_DONE.
    for (genvar k = 0; k < C_BEATS; k++) begin : g_beat
        assign w_wb_beat[k] = w_wb_data[k*BUS_WIDTH +: BUS_WIDTH];
        assign w_fill_merged[k*BUS_WIDTH +: BUS_WIDTH] =
            (k == C_BEATS - 1) ? bus_rdata : r_fill[k];
    end

    assign w_issue_idx  = r_issue_cnt[C_IDX_W-1:0];
    assign w_resp_idx   = r_resp_cnt[C_IDX_W-1:0];
    assign w_issue_more = (r_issue_cnt < C_ALL_BEATS);
    assign w_beat_base  = (r_state == WR_BURST) ? w_wb_addr : r_rd_base;
    assign w_beat_addr  = w_beat_base + (ADDR_WIDTH'(w_issue_idx) << C_BYTE_SHIFT);
    assign w_grant      = bus_req & bus_gnt;
    assign w_wb_pop     = (r_state == WR_BURST) & bus_gnt & (r_issue_cnt == C_LAST_BEAT);
    assign w_last_resp  = (r_state == RD_BURST) & bus_rvalid & (r_resp_cnt == C_LAST_BEAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A write pulse seen in IDLE wins over a held read so a fill of the same
    // line observes the written-back data.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_wb_full || mem_write_en) begin
                    w_state_next = WR_BURST;
                end else if (mem_read_en) begin
                    w_state_next = RD_BURST;
                end
            end
            WR_BURST: if (w_wb_pop)    w_state_next = IDLE;
            RD_BURST: if (w_last_resp) w_state_next = RD_DONE;
            RD_DONE:                   w_state_next = IDLE;
            default:                   w_state_next = IDLE;
        endcase
    end

    always_comb begin
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        mem_ready = 1'b0;
        case (r_state)
            WR_BURST: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = w_beat_addr;
                bus_wdata = w_wb_beat[w_issue_idx];
            end
            RD_BURST: begin
                if (w_issue_more) begin
                    bus_req  = 1'b1;
                    bus_addr = w_beat_addr;
                end
            end
            RD_DONE:  mem_ready = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_cnt <= '0;
            r_resp_cnt  <= '0;
            r_rd_base   <= '0;
            r_rd_data   <= '0;
            for (int k = 0; k < C_BEATS; k++) begin
                r_fill[k] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    r_issue_cnt <= '0;
                    r_resp_cnt  <= '0;
                    if (w_state_next == RD_BURST) begin
                        r_rd_base <= w_line_base;
                    end
                end
                WR_BURST: begin
                    if (w_grant) begin
                        r_issue_cnt <= r_issue_cnt + 1'b1;
                    end
                end
                RD_BURST: begin
                    if (w_grant) begin
                        r_issue_cnt <= r_issue_cnt + 1'b1;
                    end
                    if (bus_rvalid && (r_resp_cnt < C_ALL_BEATS)) begin
                        r_fill[w_resp_idx] <= bus_rdata;
                        r_resp_cnt         <= r_resp_cnt + 1'b1;
                    end
                    if (w_last_resp) begin
                        r_rd_data <= w_fill_merged;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_read_data = r_rd_data;
    assign busy          = (r_state != IDLE) | w_wb_full;
    assign wr_overflow   = w_wb_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_burst_bridge
// Description : Directed self-checking bench for mem_burst_bridge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_burst_bridge;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  mem_addr;
    logic [511:0] mem_write_data;
    logic         mem_read_en;
    logic         mem_write_en;
    logic [511:0] mem_read_data;
    logic         mem_ready;
    logic         bus_req;
    logic         bus_we;
    logic [31:0]  bus_addr;
    logic [31:0]  bus_wdata;
    logic         bus_gnt;
    logic         bus_rvalid;
    logic [31:0]  bus_rdata;
    logic         busy;
    logic         wr_overflow;

    int checks = 0;
    int passes = 0;
    bit resp_en = 1'b1;

    mem_burst_bridge dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_en    (mem_read_en),
        .mem_write_en   (mem_write_en),
        .mem_read_data  (mem_read_data),
        .mem_ready      (mem_ready),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_gnt        (bus_gnt),
        .bus_rvalid     (bus_rvalid),
        .bus_rdata      (bus_rdata),
        .busy           (busy),
        .wr_overflow    (wr_overflow)
    );

    always #5 clk = ~clk;

    // Advance one cycle; memory answers an accepted read one cycle later with
    // 0xA0 + beat-offset-within-line.
    task automatic step();
        logic        acc;
        logic [31:0] a;
        acc = resp_en && bus_req && bus_gnt && !bus_we;
        a   = bus_addr;
        @(posedge clk);
        #1;
        bus_rvalid = acc;
        bus_rdata  = acc ? (32'hA0 + {28'd0, a[5:2]}) : 32'h0;
    endtask

    task automatic do_fill(input logic [31:0] raw, input logic [31:0] base,
                           input bit stall, input int exp_cyc, input string tag);
        int nbeat = 0;
        int stall_cnt = 0;
        int ready_cnt = 0;
        int ready_cyc = -1;
        logic [511:0] got = '0;
        logic [511:0] exp_line;
        for (int k = 0; k < 16; k++) exp_line[k*32 +: 32] = 32'hA0 + k;
        mem_addr    = raw;
        mem_read_en = 1'b1;
        bus_gnt     = 1'b1;
        for (int c = 0; c < 70; c++) begin
            if (bus_req) begin
                checks++;
                if (bus_we !== 1'b0 || bus_addr !== base + 32'(4 * nbeat))
                    $display("FAIL %s_beat%0d: addr=%h we=%b, want addr=%h we=0",
                             tag, nbeat, bus_addr, bus_we, base + 32'(4 * nbeat));
                else passes++;
                if (stall && (nbeat == 0 || nbeat == 7 || nbeat == 15) && stall_cnt < 3) begin
                    bus_gnt = 1'b0;
                    stall_cnt++;
                end else begin
                    bus_gnt = 1'b1;
                    nbeat++;
                    stall_cnt = 0;
                end
            end else begin
                bus_gnt = 1'b1;
            end
            if (mem_ready) begin
                ready_cnt++;
                ready_cyc = c;
                got = mem_read_data;
                mem_read_en = 1'b0;
            end
            step();
        end
        checks++;
        if (nbeat !== 16) $display("FAIL %s_nbeats: got %0d want 16", tag, nbeat); else passes++;
        checks++;
        if (ready_cnt !== 1) $display("FAIL %s_ready_count: got %0d want 1", tag, ready_cnt); else passes++;
        checks++;
        if (ready_cyc !== exp_cyc) $display("FAIL %s_ready_cycle: got %0d want %0d", tag, ready_cyc, exp_cyc); else passes++;
        checks++;
        if (got !== exp_line) $display("FAIL %s_data: got %h want %h", tag, got, exp_line); else passes++;
        checks++;
        if (mem_read_data !== exp_line) $display("FAIL %s_data_hold: got %h want %h", tag, mem_read_data, exp_line); else passes++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({mem_ready, bus_req, bus_we, busy, wr_overflow} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {mem_ready, bus_req, bus_we, busy, wr_overflow});
        else passes++;
        checks++;
        if (bus_addr !== 32'h0 || bus_wdata !== 32'h0)
            $display("FAIL reset_bus: addr=%h wdata=%h want 0", bus_addr, bus_wdata);
        else passes++;
        checks++;
        if (mem_read_data !== 512'h0) $display("FAIL reset_rdata: got %h want 0", mem_read_data); else passes++;
        rst_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || bus_req !== 1'b0) $display("FAIL reset_idle: busy=%b req=%b want 0 0", busy, bus_req); else passes++;
    endtask

    task automatic test_fill();
        do_fill(32'h0000_1234, 32'h0000_1200, 1'b0, 18, "fill");
    endtask

    task automatic test_backpressure();
        do_fill(32'h0000_2008, 32'h0000_2000, 1'b1, 27, "bp");
    endtask

    task automatic test_write();
        logic [511:0] wline;
        int nbeat = 0, stall_cnt = 0, last = -1, ready_cnt = 0;
        bit busy_hist [40];
        for (int k = 0; k < 16; k++) wline[k*32 +: 32] = 32'h1000 + k;
        mem_addr = 32'h4000; mem_write_data = wline; mem_write_en = 1'b1; bus_gnt = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (bus_req) begin
                checks++;
                if (bus_we !== 1'b1 || bus_addr !== 32'h4000 + 32'(4 * nbeat) || bus_wdata !== 32'h1000 + nbeat)
                    $display("FAIL wr_beat%0d: we=%b addr=%h data=%h want 1 %h %h", nbeat, bus_we,
                             bus_addr, bus_wdata, 32'h4000 + 32'(4 * nbeat), 32'h1000 + nbeat);
                else passes++;
                if (nbeat == 5 && stall_cnt < 2) begin
                    bus_gnt = 1'b0;
                    stall_cnt++;
                end else begin
                    bus_gnt = 1'b1;
                    last = c;
                    nbeat++;
                end
            end else begin
                bus_gnt = 1'b1;
            end
            busy_hist[c] = busy;
            if (mem_ready) ready_cnt++;
            step();
            if (c == 0) mem_write_en = 1'b0;
        end
        checks++;
        if (nbeat !== 16) $display("FAIL wr_nbeats: got %0d want 16", nbeat); else passes++;
        checks++;
        if (last !== 18) $display("FAIL wr_last_cycle: got %0d want 18", last); else passes++;
        checks++;
        if (busy_hist[18] !== 1'b1 || busy_hist[19] !== 1'b0)
            $display("FAIL wr_busy_clear: got %b%b want 10", busy_hist[18], busy_hist[19]);
        else passes++;
        checks++;
        if (ready_cnt !== 0) $display("FAIL wr_no_ready: got %0d want 0", ready_cnt); else passes++;
    endtask

    task automatic test_wr_then_rd();
        logic [511:0] wline, exp_line, got;
        int nw = 0, nr = 0, ready_cnt = 0;
        got = '0;
        for (int k = 0; k < 16; k++) begin
            wline[k*32 +: 32]    = 32'h5500 + k;
            exp_line[k*32 +: 32] = 32'hA0 + k;
        end
        mem_addr = 32'h800; mem_write_data = wline; mem_write_en = 1'b1; mem_read_en = 1'b1; bus_gnt = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (bus_req && bus_we) begin
                checks++;
                if (bus_addr !== 32'h800 + 32'(4 * nw) || bus_wdata !== 32'h5500 + nw)
                    $display("FAIL wrrd_wbeat%0d: addr=%h data=%h want %h %h", nw, bus_addr, bus_wdata,
                             32'h800 + 32'(4 * nw), 32'h5500 + nw);
                else passes++;
                nw++;
            end else if (bus_req) begin
                if (nr == 0) begin
                    checks++;
                    if (nw !== 16 || bus_addr !== 32'h800)
                        $display("FAIL wrrd_order: first read addr=%h after %0d writes, want 800 after 16", bus_addr, nw);
                    else passes++;
                end
                nr++;
            end
            if (mem_ready) begin
                ready_cnt++;
                got = mem_read_data;
                mem_read_en = 1'b0;
            end
            step();
            if (c == 0) mem_write_en = 1'b0;
        end
        checks++;
        if (nw !== 16 || nr !== 16) $display("FAIL wrrd_counts: writes=%0d reads=%0d want 16 16", nw, nr); else passes++;
        checks++;
        if (ready_cnt !== 1 || got !== exp_line)
            $display("FAIL wrrd_fill: ready=%0d data=%h want 1 %h", ready_cnt, got, exp_line);
        else passes++;
    endtask

    task automatic test_overflow();
        logic [511:0] wline;
        int nw = 0;
        for (int k = 0; k < 16; k++) wline[k*32 +: 32] = 32'h1000 + k;
        mem_addr = 32'h4000; mem_write_data = wline; mem_write_en = 1'b1; bus_gnt = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (c == 1) begin
                checks++;
                if (wr_overflow !== 1'b0) $display("FAIL ovf_early: got %b want 0", wr_overflow); else passes++;
            end
            if (c == 2) begin
                mem_addr = 32'h8000; mem_write_data = {16{32'hFFFF_0000}}; mem_write_en = 1'b1;
            end
            if (c == 3) begin
                checks++;
                if (wr_overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", wr_overflow); else passes++;
            end
            if (bus_req) begin
                checks++;
                if (bus_we !== 1'b1 || bus_addr !== 32'h4000 + 32'(4 * nw) || bus_wdata !== 32'h1000 + nw)
                    $display("FAIL ovf_beat%0d: we=%b addr=%h data=%h want 1 %h %h", nw, bus_we, bus_addr,
                             bus_wdata, 32'h4000 + 32'(4 * nw), 32'h1000 + nw);
                else passes++;
                nw++;
            end
            step();
            mem_write_en = 1'b0;
        end
        checks++;
        if (nw !== 16) $display("FAIL ovf_nbeats: got %0d want 16", nw); else passes++;
        checks++;
        if (wr_overflow !== 1'b1 || busy !== 1'b0)
            $display("FAIL ovf_sticky: ovf=%b busy=%b want 1 0", wr_overflow, busy);
        else passes++;
    endtask

    task automatic test_reset_mid_read();
        int ng = 0;
        mem_addr = 32'h3000; mem_read_en = 1'b1; bus_gnt = 1'b1; resp_en = 1'b1;
        for (int c = 0; c < 20 && ng < 5; c++) begin
            if (bus_req && bus_gnt) ng++;
            step();
        end
        checks++;
        if (bus_req !== 1'b1 || ng !== 5) $display("FAIL rst_pre: req=%b grants=%0d want 1 5", bus_req, ng); else passes++;
        resp_en = 1'b0; mem_read_en = 1'b0; bus_rvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_req !== 1'b0 || busy !== 1'b0 || wr_overflow !== 1'b0 || mem_read_data !== 512'h0)
            $display("FAIL rst_abort: req=%b busy=%b ovf=%b rdata_zero=%b want 0 0 0 1",
                     bus_req, busy, wr_overflow, mem_read_data == 512'h0);
        else passes++;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_rvalid = 1'b1;
            bus_rdata  = 32'hDEAD_0000 + i;
            @(posedge clk);
            #1;
        end
        bus_rvalid = 1'b0;
        checks++;
        if (busy !== 1'b0 || mem_ready !== 1'b0) $display("FAIL rst_late_rvalid: busy=%b ready=%b want 0 0", busy, mem_ready); else passes++;
        resp_en = 1'b1;
        do_fill(32'h0000_3010, 32'h0000_3000, 1'b0, 18, "refill");
    endtask

    initial begin
        rst_n = 1'b0; mem_addr = '0; mem_write_data = '0; mem_read_en = 1'b0; mem_write_en = 1'b0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        test_reset();
        test_fill();
        test_backpressure();
        test_write();
        test_wr_then_rd();
        test_overflow();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
